// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
//
// WIDTH-bit ripple-carry adder with registered copies of its result.
// The sum and carry-out are purely combinational. The registered copies
// update on every rising clk edge, with one cycle of latency.
//
// Optional feature macro: FULL_ADDER_STATS_EN
//   When this macro is defined, a saturating counter is added. It counts the
//   clock edges at which carryOut is high, and it is exported on carry_cnt.
//
// Ports (in declaration order):
//   carryIn   in   1       carry into bit 0
//   in1       in   WIDTH   addend A
//   in2       in   WIDTH   addend B
//   out       out  WIDTH   combinational sum
//   carryOut  out  1       combinational carry out of the MSB
//   clk       in   1       rising-edge clock (registered outputs only)
//   rst       in   1       synchronous active-high reset
//   sum_q     out  WIDTH   registered copy of out
//   carry_q   out  1       registered copy of carryOut
//   carry_cnt out  CNT_W   saturating carry-event count (FULL_ADDER_STATS_EN)
// ---------------------------------------------------------------------------
module full_adder #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             carryIn,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] out,
    output logic             carryOut,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] sum_q,
    output logic             carry_q
`ifdef FULL_ADDER_STATS_EN
    ,
    output logic [CNT_W-1:0] carry_cnt
`endif
);

    // Ripple chain of 1-bit cells. Each cell is built from two half adders
    // plus an OR. Each cell reads its carry-in from the previous cell's own
    // signal, not from a shared vector. This keeps the chain free of
    // self-referencing vector bits.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : gen_cell
            logic cin_b;
            logic ha1_s, ha1_c;
            logic ha2_c;
            logic cout_b;

            if (gi == 0) begin : gen_first
                assign cin_b = carryIn;
            end else begin : gen_rest
                assign cin_b = gen_cell[gi-1].cout_b;
            end

            // first half adder: operand bits
            assign ha1_s   = in1[gi] ^ in2[gi];
            assign ha1_c   = in1[gi] & in2[gi];
            // second half adder: partial sum plus incoming carry
            assign out[gi] = ha1_s ^ cin_b;
            assign ha2_c   = ha1_s & cin_b;
            assign cout_b  = ha1_c | ha2_c;
        end
    endgenerate

    assign carryOut = gen_cell[WIDTH-1].cout_b;

    // Registered copies of the result; reset wins over the load.
    logic [WIDTH-1:0] sum_d;
    logic             carry_d;

    assign sum_d   = out;
    assign carry_d = carryOut;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

`ifdef FULL_ADDER_STATS_EN
    // Carry-event counter. It sticks at all-ones until the next reset.
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (carryOut && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign carry_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_full_adder.sv
// ---------------------------------------------------------------------------
// tb_full_adder
//
// Two instances are used:
//   u_w1 : WIDTH=1. Its clock and reset are left at X. It gets an exhaustive
//          sweep of the combinational truth table.
//   u_w8 : WIDTH=8, CNT_W=2. It gets directed plus random vectors. The
//          combinational outputs are checked right after each drive. The
//          expected registered response goes into a scoreboard queue, and an
//          independent monitor pops and compares it after each clock edge.
// ---------------------------------------------------------------------------
module tb_full_adder;

    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic [1:0] n;
    } exp_t;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    exp_t sb[$];
    exp_t mon_e;

    int   cnt_m = 0;   // reference carry-event count (saturates at 3)

    // ---------------- WIDTH=1 instance, clock/reset never driven -----------
    logic       clk1, rst1;
    logic       cin1;
    logic [0:0] a1, b1;
    logic [0:0] o1, sq1;
    logic       co1, cq1;
`ifdef FULL_ADDER_STATS_EN
    logic [7:0] cnt1;
`endif

    full_adder #(.WIDTH(1)) u_w1 (
        .carryIn  (cin1),
        .in1      (a1),
        .in2      (b1),
        .out      (o1),
        .carryOut (co1),
        .clk      (clk1),
        .rst      (rst1),
        .sum_q    (sq1),
        .carry_q  (cq1)
`ifdef FULL_ADDER_STATS_EN
        ,
        .carry_cnt(cnt1)
`endif
    );

    // ---------------- WIDTH=8 instance ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cin = 1'b0;
    logic [7:0] a = 8'h00, b = 8'h00;
    logic [7:0] o, sq;
    logic       co, cq;
`ifdef FULL_ADDER_STATS_EN
    logic [1:0] cnt;
`endif

    full_adder #(.WIDTH(8), .CNT_W(2)) u_w8 (
        .carryIn  (cin),
        .in1      (a),
        .in2      (b),
        .out      (o),
        .carryOut (co),
        .clk      (clk),
        .rst      (rst),
        .sum_q    (sq),
        .carry_q  (cq)
`ifdef FULL_ADDER_STATS_EN
        ,
        .carry_cnt(cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Drive one vector at the falling edge, then check the combinational
    // result. After that, queue the response expected after the next rising
    // edge.
    task automatic cycle(input logic r, input logic [7:0] x, input logic [7:0] y, input logic ci);
        int   total;
        exp_t e;
        @(negedge clk);
        rst = r;
        a   = x;
        b   = y;
        cin = ci;
        #1;
        total = int'(x) + int'(y) + int'(ci);
        check("comb_sum", {24'd0, o}, total & 'hFF);
        check("comb_carry", {31'd0, co}, (total >> 8) & 1);
        if (r) begin
            e.s   = 8'h00;
            e.c   = 1'b0;
            cnt_m = 0;
        end else begin
            e.s = 8'(total & 'hFF);
            e.c = 1'((total >> 8) & 1);
            if (e.c && cnt_m < 3) cnt_m++;
        end
        e.n = 2'(cnt_m);
        sb.push_back(e);
    endtask

    // Monitor: every rising edge presents one registered response.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            txn++;
            $display("txn %0d sum_q=%02h carry_q=%0b exp_sum=%02h exp_carry=%0b",
                     txn, sq, cq, mon_e.s, mon_e.c);
            check("reg_sum", {24'd0, sq}, {24'd0, mon_e.s});
            check("reg_carry", {31'd0, cq}, {31'd0, mon_e.c});
`ifdef FULL_ADDER_STATS_EN
            check("carry_cnt", {30'd0, cnt}, {30'd0, mon_e.n});
`endif
        end
    end

    initial begin
        int t;
        int drain;

        clk1 = 1'bx;
        rst1 = 1'bx;

        // Exhaustive sweep of the 1-bit adder, with no clock on that instance.
        for (int i = 0; i < 8; i++) begin
            cin1 = i[2];
            a1   = i[1];
            b1   = i[0];
            #10;
            t = i[2] + i[1] + i[0];
            $display("w1 cin=%0b in1=%0b in2=%0b -> out=%0b carry=%0b", cin1, a1, b1, o1, co1);
            check("w1_out", {31'd0, o1}, t & 1);
            check("w1_carry", {31'd0, co1}, t >> 1);
        end

        // Reset, then the boundary vectors.
        cycle(1'b1, 8'h12, 8'h34, 1'b0);
        cycle(1'b0, 8'hFF, 8'h01, 1'b0);
        cycle(1'b0, 8'h7F, 8'h80, 1'b1);
        cycle(1'b0, 8'h01, 8'h01, 1'b1);

        // Hold a carry for 5 edges, which drives the counter into saturation.
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'hFF, 8'h01, 1'b0);

        // Reset held while the inputs keep toggling.
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));

        // Random traffic with occasional resets.
        for (int i = 0; i < 200; i++) begin
            cycle(($urandom_range(0, 15) == 0), 8'($urandom), 8'($urandom), 1'($urandom));
        end

        // Let the monitor drain the scoreboard, bounded in cycles.
        drain = 0;
        while (sb.size() != 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        #2;
        check("scoreboard_drain", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
- REQ-001 Parameter WIDTH, default 1: operand/sum width in bits; legal range 1..32.
- REQ-002 Parameter CNT_W, default 8: width of the carry-event counter.
- REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
- REQ-004 clk  input  1  rising-edge clock for registered outputs only.
- REQ-005 rst  input  1  synchronous, active-high reset.
- REQ-006 carryIn  input  1  carry into bit 0.
- REQ-007 in1  input  WIDTH  addend A.
- REQ-008 in2  input  WIDTH  addend B.
- REQ-009 out  output  WIDTH  combinational sum.
- REQ-010 carryOut  output  1  combinational carry out of the MSB.
- REQ-011 sum_q  output  WIDTH  registered copy of out.
- REQ-012 carry_q  output  1  registered copy of carryOut.
- REQ-013 carry_cnt  output  CNT_W  saturating count of carry events; present only with FULL_ADDER_STATS_EN.
- REQ-014 Port declaration order SHALL be carryIn, in1, in2, out, carryOut, clk, rst, sum_q, carry_q, then carry_cnt, so that 5-port positional instantiation maps correctly.

Function
- REQ-015 {carryOut, out} SHALL equal in1 + in2 + carryIn, evaluated at WIDTH+1 bits with no truncation.
- REQ-016 For WIDTH=1 the block SHALL behave as the standard full adder: out = in1 XOR in2 XOR carryIn; carryOut = majority(in1, in2, carryIn).
- REQ-017 For WIDTH>1 the implementation SHALL be a ripple chain of 1-bit full-adder cells, each cell built from two half adders plus an OR.
- REQ-018 out and carryOut SHALL be purely combinational, settle within the same simulation time step as an input change, and not depend on clk or rst, including when clk or rst is undriven (X/Z).
- REQ-019 On each rising clk edge with rst=0, sum_q and carry_q SHALL load the current out and carryOut: one-cycle latency, no enable.
- REQ-020 Any X/Z on carryIn, in1 or in2 MAY propagate to the outputs; no X masking is required.

Reset
- REQ-021 When rst=1 at a rising clk edge, sum_q and carry_q SHALL be set to 0, and carry_cnt to 0 when present.
- REQ-022 Reset SHALL NOT affect out or carryOut.
- REQ-023 Reset SHALL take priority over every load or count at the same edge.
- REQ-024 There SHALL be no asynchronous reset path; before the first reset edge the registered outputs are undefined.

Configuration
- REQ-025 Macro FULL_ADDER_STATS_EN, when defined: carry_cnt exists and increments by 1 at each rising clk edge with rst=0 and carryOut=1.
- REQ-026 carry_cnt SHALL saturate at 2^CNT_W-1 and hold there until reset.
- REQ-027 When FULL_ADDER_STATS_EN is undefined: the carry_cnt port and counter logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
- REQ-028 WIDTH=1, no clock driven; sweep all 8 (carryIn, in1, in2) combinations, checking 10 time units after each: 000->out 0/carry 0; 010->1/0; 001->1/0; 011->0/1; 100->1/0; 110->0/1; 101->0/1; 111->1/1.
- REQ-029 WIDTH=8: in1=0xFF, in2=0x01, carryIn=0 -> out=0x00, carryOut=1; in1=0x7F, in2=0x80, carryIn=1 -> out=0x00, carryOut=1.
- REQ-030 Registered path: rst=1 for 1 edge -> sum_q=0, carry_q=0; then drive in1=1, in2=1, carryIn=1 with rst=0 -> after the next edge sum_q=1, carry_q=1.
- REQ-031 STATS_EN, CNT_W=2: hold carryOut=1 for 5 edges -> carry_cnt sequence 1, 2, 3, 3, 3; then assert rst -> 0 at the next edge.
- REQ-032 Assert rst while inputs toggle -> out/carryOut keep tracking inputs combinationally; registered outputs stay 0.
